// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: 640x480@60 defaults,
// coordinate/colour widths and the colour-bar table used by VIDEO_TEST_PATTERN_EN.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit H_POL_DEF    = 1'b0;
  localparam bit V_POL_DEF    = 1'b0;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int COORD_W = 16;
  localparam int COLOR_W = 8;
  localparam int RGB_W   = 3 * COLOR_W;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [RGB_W-1:0] BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [RGB_W-1:0] bar_color(input logic [COORD_W-1:0] idx);
    logic [RGB_W-1:0] c;
    c = '0;
    if (idx < 16'd8) begin
      c = BAR_TABLE[idx[2:0]];
    end
    return c;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous reset to a programmable value;
// used to align timing decodes and compositor colour with the output register.
module video_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = i_d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_out.sv
// Raster counters, sync/DE decode and registered RGB output stage.
// Optional colour-bar generator enabled by defining VIDEO_TEST_PATTERN_EN.
module video_timing_out
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit H_POL    = H_POL_DEF,
  parameter bit V_POL    = V_POL_DEF,
  parameter int PIPE_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic               i_test_pattern,
`endif
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_v_sync,
  input  logic [COLOR_W-1:0] i_red,
  input  logic [COLOR_W-1:0] i_green,
  input  logic [COLOR_W-1:0] i_blue,
  output logic [COLOR_W-1:0] o_vid_red,
  output logic [COLOR_W-1:0] o_vid_green,
  output logic [COLOR_W-1:0] o_vid_blue,
  output logic               o_vid_de,
  output logic               o_vid_h_sync,
  output logic               o_vid_v_sync,
  output logic               o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_totals
    $error("video_timing_out: H_TOTAL/V_TOTAL exceed the 16-bit counter range");
  end
  if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
    $error("video_timing_out: PIPE_LAT must be in 1..4");
  end

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]         TIM_RST  = {~V_POL, ~H_POL, 1'b0};

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               de_s, hs_s, vs_s;
  logic [2:0]         tim_s, tim_dly;
  logic [RGB_W-1:0]   rgb_in_s, rgb_dly;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    x_d = x_q + COORD_W'(1);
    y_d = y_q;
    if (x_q == X_MAX) begin
      x_d = '0;
      if (y_q == Y_MAX) begin
        y_d = '0;
      end else begin
        y_d = y_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    de_s = (x_q < X_ACT) && (y_q < Y_ACT);
    hs_s = ((x_q >= HS_START) && (x_q < HS_END)) ? H_POL : ~H_POL;
    vs_s = ((y_q >= VS_START) && (y_q < VS_END)) ? V_POL : ~V_POL;
  end

  assign tim_s    = {vs_s, hs_s, de_s};
  assign rgb_in_s = {i_red, i_green, i_blue};

`ifdef VIDEO_TEST_PATTERN_EN
  localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_ACTIVE / 8);
  logic [COORD_W-1:0] x_dly;
  logic [COORD_W-1:0] bar_idx_s;
  assign bar_idx_s = x_dly / BAR_W;
`endif

  // PIPE_LAT-1 alignment stages; the output register supplies the last clock.
  if (PIPE_LAT > 1) begin : g_dly
    video_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT - 1), .RST_VAL(TIM_RST)) u_tim_dly (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(tim_s), .o_q(tim_dly)
    );
    video_delay_line #(.WIDTH(RGB_W), .DEPTH(PIPE_LAT - 1), .RST_VAL({RGB_W{1'b0}})) u_rgb_dly (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(rgb_in_s), .o_q(rgb_dly)
    );
`ifdef VIDEO_TEST_PATTERN_EN
    video_delay_line #(.WIDTH(COORD_W), .DEPTH(PIPE_LAT - 1), .RST_VAL({COORD_W{1'b0}})) u_x_dly (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(x_q), .o_q(x_dly)
    );
`endif
  end else begin : g_nodly
    assign tim_dly = tim_s;
    assign rgb_dly = rgb_in_s;
`ifdef VIDEO_TEST_PATTERN_EN
    assign x_dly   = x_q;
`endif
  end

  always_comb begin
    de_d  = tim_dly[0];
    hs_d  = tim_dly[1];
    vs_d  = tim_dly[2];
    rgb_d = '0;
    if (tim_dly[0]) begin
`ifdef VIDEO_TEST_PATTERN_EN
      if (i_test_pattern) begin
        rgb_d = bar_color(bar_idx_s);
      end else begin
        rgb_d = rgb_dly;
      end
`else
      rgb_d = rgb_dly;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_v_sync      = vs_s;
  assign o_frame_start = (x_q == '0) && (y_q == '0);
  assign o_vid_red     = rgb_q[23:16];
  assign o_vid_green   = rgb_q[15:8];
  assign o_vid_blue    = rgb_q[7:0];
  assign o_vid_de      = de_q;
  assign o_vid_h_sync  = hs_q;
  assign o_vid_v_sync  = vs_q;

endmodule

// File: tb/tb_video_timing_out.sv
// Directed bench: default 640x480 instance (PIPE_LAT=1) plus a tiny-raster
// instance (24x15 totals, PIPE_LAT=3, V_POL=1) checked against a raster model.
module tb_video_timing_out;

  logic clk = 1'b0;
  logic rst;
  logic tp0, tp1;
  always #5 clk = ~clk;

  logic [15:0] x0, y0, x1, y1;
  logic        ov0, fs0, de0, hs0, vsv0;
  logic        ov1, fs1, de1, hs1, vsv1;
  logic [7:0]  r0, g0, b0, vr0, vg0, vb0;
  logic [7:0]  r1, g1, b1, vr1, vg1, vb1;
  logic [23:0] rgb0, rgb1;

  assign rgb0 = {vr0, vg0, vb0};
  assign rgb1 = {vr1, vg1, vb1};
  // Compositor stand-in for the small instance: colour encodes the coordinate.
  assign r1 = x1[7:0];
  assign g1 = y1[7:0];
  assign b1 = 8'h5A;

  video_timing_out dut0 (
    .i_clk(clk), .i_rst(rst),
`ifdef VIDEO_TEST_PATTERN_EN
    .i_test_pattern(tp0),
`endif
    .o_x(x0), .o_y(y0), .o_v_sync(ov0),
    .i_red(r0), .i_green(g0), .i_blue(b0),
    .o_vid_red(vr0), .o_vid_green(vg0), .o_vid_blue(vb0),
    .o_vid_de(de0), .o_vid_h_sync(hs0), .o_vid_v_sync(vsv0),
    .o_frame_start(fs0)
  );

  video_timing_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .PIPE_LAT(3)
  ) dut1 (
    .i_clk(clk), .i_rst(rst),
`ifdef VIDEO_TEST_PATTERN_EN
    .i_test_pattern(tp1),
`endif
    .o_x(x1), .o_y(y1), .o_v_sync(ov1),
    .i_red(r1), .i_green(g1), .i_blue(b1),
    .o_vid_red(vr1), .o_vid_green(vg1), .o_vid_blue(vb1),
    .o_vid_de(de1), .o_vid_h_sync(hs1), .o_vid_v_sync(vsv1),
    .o_frame_start(fs1)
  );

  typedef struct {
    int          cyc;
    logic [15:0] x;
    logic [15:0] y;
    logic        fs;
    logic        de;
    logic        hs;
    logic [23:0] rgb;
  } vec_t;

  vec_t vec [14];
  int tests = 0;
  int fails = 0;
  int c = 0;
  int model_bad = 0;
  int vs_cnt = 0;
  int fs_cnt = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  // Small instance: 24 clocks/line, 15 lines/frame, outputs lag coordinates by 3.
  task automatic model_check();
    int xk, yk, j, xj, yj;
    logic ede, ehs, evs, efs, eov;
    logic [23:0] ergb;
    xk  = c % 24;
    yk  = (c / 24) % 15;
    efs = (xk == 0) && (yk == 0);
    eov = (yk >= 10) && (yk < 12);
    if (c < 3) begin
      ede = 1'b0; ehs = 1'b1; evs = 1'b0; ergb = 24'h0;
    end else begin
      j    = c - 3;
      xj   = j % 24;
      yj   = (j / 24) % 15;
      ede  = (xj < 16) && (yj < 8);
      ehs  = !((xj >= 18) && (xj < 21));
      evs  = (yj >= 10) && (yj < 12);
      ergb = ede ? {8'(xj), 8'(yj), 8'h5A} : 24'h0;
    end
    if ({x1, y1, fs1, ov1, de1, hs1, vsv1, rgb1} !==
        {16'(xk), 16'(yk), efs, eov, ede, ehs, evs, ergb}) begin
      model_bad++;
    end
    if (c < 720) begin
      if (ov1) vs_cnt++;
      if (fs1) fs_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
    if (model_on) model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_lo, last_lo, lo_cnt;
    vec[0]  = '{0,    16'd0,   16'd0, 1'b1, 1'b0, 1'b1, 24'h000000};
    vec[1]  = '{1,    16'd1,   16'd0, 1'b0, 1'b1, 1'b1, 24'hFF8001};
    vec[2]  = '{2,    16'd2,   16'd0, 1'b0, 1'b1, 1'b1, 24'hFF8001};
    vec[3]  = '{640,  16'd640, 16'd0, 1'b0, 1'b1, 1'b1, 24'hFF8001};
    vec[4]  = '{641,  16'd641, 16'd0, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[5]  = '{656,  16'd656, 16'd0, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[6]  = '{657,  16'd657, 16'd0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vec[7]  = '{752,  16'd752, 16'd0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vec[8]  = '{753,  16'd753, 16'd0, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[9]  = '{799,  16'd799, 16'd0, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[10] = '{800,  16'd0,   16'd1, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[11] = '{801,  16'd1,   16'd1, 1'b0, 1'b1, 1'b1, 24'hFF8001};
    vec[12] = '{1599, 16'd799, 16'd1, 1'b0, 1'b0, 1'b1, 24'h000000};
    vec[13] = '{1600, 16'd0,   16'd2, 1'b0, 1'b0, 1'b1, 24'h000000};

    tp0 = 1'b0; tp1 = 1'b0;
    r0 = 8'hFF; g0 = 8'h80; b0 = 8'h01;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0;
    model_on = 1'b1;
    model_check();

    for (int i = 0; i < 14; i++) begin
      while (c < vec[i].cyc) tick();
      chk("x",     32'(x0),   32'(vec[i].x));
      chk("y",     32'(y0),   32'(vec[i].y));
      chk("frame_start", 32'(fs0), 32'(vec[i].fs));
      chk("vid_de", 32'(de0), 32'(vec[i].de));
      chk("vid_hs", 32'(hs0), 32'(vec[i].hs));
      chk("vid_rgb", 32'(rgb0), 32'(vec[i].rgb));
      chk("vs_idle", {30'd0, ov0, vsv0}, 32'd3);
    end
    chk("dut1_vsync_cycles", 32'(vs_cnt), 32'd96);
    chk("dut1_frame_pulses", 32'(fs_cnt), 32'd2);

    // Count h_sync low clocks across one full line.
    first_lo = -1; last_lo = -1; lo_cnt = 0;
    repeat (800) begin
      tick();
      if (hs0 === 1'b0) begin
        lo_cnt++;
        if (first_lo < 0) first_lo = int'(x0);
        last_lo = int'(x0);
      end
    end
    chk("hs_low_clocks", 32'(lo_cnt), 32'd96);
    chk("hs_first_low_x", 32'(first_lo), 32'd657);
    chk("hs_last_low_x", 32'(last_lo), 32'd752);
    chk("dut1_model", 32'(model_bad), 32'd0);

    // Mid-line reset while both instances are inside active video.
    while (c < 2700) tick();
    chk("pre_rst_x", 32'(x0), 32'd300);
    chk("pre_rst_de", 32'(de0), 32'd1);
    model_on = 1'b0;
    do_reset();
    chk("rst_x", 32'(x0), 32'd0);
    chk("rst_y", 32'(y0), 32'd0);
    chk("rst_de", 32'(de0), 32'd0);
    chk("rst_rgb", 32'(rgb0), 32'd0);
    chk("rst_syncs", {30'd0, hs0, vsv0}, 32'd3);
    chk("rst1_x", 32'(x1), 32'd0);
    chk("rst1_de_rgb", {7'd0, de1, rgb1}, 32'd0);
    chk("rst1_syncs", {30'd0, hs1, vsv1}, 32'd2);
    rst = 1'b0;
    c = 0;
    model_bad = 0;
    model_on = 1'b1;
    model_check();
    chk("rel_x0", 32'(x0), 32'd0);
    tick();
    chk("rel_x1", 32'(x0), 32'd1);
    chk("rel_de", 32'(de0), 32'd1);
    chk("rel_rgb", 32'(rgb0), 32'hFF8001);
    tick();
    chk("rel_x2", 32'(x0), 32'd2);
    repeat (60) tick();
    chk("dut1_model_after_rst", 32'(model_bad), 32'd0);

`ifdef VIDEO_TEST_PATTERN_EN
    begin
      int tcyc [5];
      logic [24:0] texp [5];
      tcyc[0] = 1;   texp[0] = {1'b1, 24'hFFFFFF};
      tcyc[1] = 80;  texp[1] = {1'b1, 24'hFFFFFF};
      tcyc[2] = 81;  texp[2] = {1'b1, 24'hFFFF00};
      tcyc[3] = 640; texp[3] = {1'b1, 24'h000000};
      tcyc[4] = 641; texp[4] = {1'b0, 24'h000000};
      model_on = 1'b0;
      tp0 = 1'b1;
      do_reset();
      rst = 1'b0;
      c = 0;
      for (int i = 0; i < 5; i++) begin
        while (c < tcyc[i]) tick();
        chk("test_pattern", {7'd0, de0, rgb0}, {7'd0, texp[i]});
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
